uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Byte FIFO directly downstream of the 8x-oversampling UART receiver.
//  Captures each rx_data byte on its one-cycle rx_rdy pulse and buffers it until the host reads it.
//  Absorbs bursts of back-to-back frames; reports level, full/empty and a sticky overflow.
//  Single clock domain (clk), same clock as the receiver's output stage.
// PARAMETERS
//  DEPTH   16  number of byte entries; power of 2, >= 4
//  AW      4   pointer width, log2(DEPTH)
//  THRESH  12  level at/above which irq asserts; 1..DEPTH (used only with the IRQ macro)
// PORTS
//  clk       in   1     system clock
//  rst       in   1     reset, asynchronous, active-high
//  wr_data   in   8     received byte (receiver rx_data)
//  wr_vld    in   1     one-cycle write strobe (receiver rx_rdy)
//  rd_en     in   1     host read request, one byte per high cycle
//  rd_data   out  8     read byte, registered
//  rd_vld    out  1     one-cycle pulse: rd_data valid
//  empty     out  1     count == 0
//  full      out  1     count == DEPTH
//  count     out  AW+1  current fill level, 0..DEPTH
//  overflow  out  1     sticky: a byte was dropped because the FIFO was full
//  ovf_clr   in   1     clears overflow
//  irq       out  1     level interrupt (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): rd_data=0, rd_vld=0, count=0, empty=1, full=0, overflow=0, irq=0; wr/rd ptrs=0.
//  - Storage: DEPTH x 8 register array; wr_ptr/rd_ptr are AW bits, wrap DEPTH-1 -> 0 (modulo).
//  - count is a separate AW+1-bit register; empty/full are registered and derived from the next count.
//  - Write accept: wr_vld && (!full || rd_accept). Stores at wr_ptr, wr_ptr+1.
//  - Read accept (rd_accept): rd_en && !empty. rd_data <= mem[rd_ptr], rd_ptr+1; rd_vld=1 on the
//    following cycle (1-cycle latency). rd_vld=0 in every cycle with no accepted read.
//  - rd_data holds its last value when there is no read; it does not change on a rejected read.
//  - rd_en while empty: ignored, no pointer change, rd_vld stays 0, no error flag.
//  - Simultaneous write+read accept: count unchanged; both pointers advance.
//  - Full + wr_vld + rd_en: read frees a slot in the same cycle; write accepted, no overflow.
//  - Empty + wr_vld + rd_en: write accepted, read rejected (no bypass); count 0 -> 1.
//  - Full + wr_vld, no read: byte dropped, memory/pointers unchanged, overflow <= 1.
//  - overflow: cleared by ovf_clr; set event in the same cycle as ovf_clr wins (overflow stays 1).
//  - count arithmetic: +1 on write only, -1 on read only; it never wraps (guarded by full/empty).
//  - Reset mid-operation: contents discarded, all outputs return to reset values immediately.
//  - Throughput: one write and one read per clk; wr_vld is never back-to-back in practice,
//    but back-to-back writes are fully supported.
// CONFIGURATION
//  - Macro UART_RX_FIFO_THRESH_IRQ_EN defined: irq is a registered level, 1 when the next
//    count >= THRESH, else 0. It asserts the cycle after the write reaching THRESH and deasserts
//    the cycle after the read dropping count below THRESH.
//  - Not defined: irq is tied to 0, no threshold logic is built, and THRESH is ignored.
// TESTING
//  1. Reset, write 0xA5 (wr_vld pulse), then rd_en -> count 1->0; next cycle rd_vld=1, rd_data=0xA5; empty=1.
//  2. Write 16 bytes 0x00..0x0F -> full=1, count=16; read all 16 -> order 0x00..0x0F, empty=1, ptrs wrapped to 0.
//  3. Full, write 0x55 with no read -> overflow=1, count=16, later reads return no 0x55;
//     ovf_clr -> overflow=0. ovf_clr together with another drop -> overflow stays 1.
//  4. Full, wr_vld(0x77)+rd_en same cycle -> rd_data=old head, count stays 16, overflow=0, 0x77 read last.
//  5. Empty, wr_vld(0x3C)+rd_en same cycle -> rd_vld=0, count=1; rd_en on empty FIFO -> rd_vld=0, count 0.
//  6. With UART_RX_FIFO_THRESH_IRQ_EN, THRESH=12: 12th write -> irq=1 next cycle; one read -> irq=0;
//     without the macro irq=0 throughout. Async rst with count=9 -> all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: write/read/status bundle between the UART receiver, host and byte FIFO.
interface uart_rx_fifo_if #(parameter int AW = 4);
  logic [7:0]  wr_data;
  logic        wr_vld;
  logic        rd_en;
  logic        ovf_clr;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overflow;
  logic        irq;
  modport master (output wr_data, wr_vld, rd_en, ovf_clr,
                  input  rd_data, rd_vld, empty, full, count, overflow, irq);
  modport slave  (input  wr_data, wr_vld, rd_en, ovf_clr,
                  output rd_data, rd_vld, empty, full, count, overflow, irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind the UART receiver with level, full/empty and sticky overflow.
// Define UART_RX_FIFO_THRESH_IRQ_EN to build the registered count >= THRESH level interrupt.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 12
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam logic [AW:0]   C1 = (AW+1)'(1);
  localparam logic [AW:0]   CD = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] P1 = AW'(1);
  if (THRESH < 1 || THRESH > DEPTH || (1 << AW) != DEPTH || DEPTH < 4) begin : g_bad_param
    $error("uart_rx_fifo: inconsistent DEPTH/AW/THRESH");
  end
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_cnt_nxt;
  logic [7:0]    r_rd_data;
  logic          r_rd_vld, r_empty, r_full, r_ovf;
  logic          w_rd, w_wr, w_drop;
  // a read frees its slot in the same cycle, so a full FIFO still accepts a write alongside it
  assign w_rd      = bus.rd_en && !r_empty;
  assign w_wr      = bus.wr_vld && (!r_full || w_rd);
  assign w_drop    = bus.wr_vld && !w_wr;
  assign w_cnt_nxt = (w_wr && !w_rd) ? r_count + C1 : (w_rd && !w_wr) ? r_count - C1 : r_count;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.wr_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + P1;
      if (w_rd) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + P1;
      end
      r_rd_vld <= w_rd;
      r_count  <= w_cnt_nxt;
      r_empty  <= w_cnt_nxt == '0;
      r_full   <= w_cnt_nxt == CD;
      r_ovf    <= w_drop || (r_ovf && !bus.ovf_clr);
    end
  end
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  localparam logic [AW:0] TH = (AW+1)'(THRESH);
  logic r_irq;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= w_cnt_nxt >= TH;
  end
  assign bus.irq = r_irq;
`else
  assign bus.irq = 1'b0;
`endif
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_vld   = r_rd_vld;
  assign bus.empty    = r_empty;
  assign bus.full     = r_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vector table plus hand sequences for wrap, overflow, irq and async reset.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  uart_rx_fifo_if #(.AW(4)) bus ();
  uart_rx_fifo #(.DEPTH(16), .AW(4), .THRESH(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       re;
    logic       oc;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       eo;
  } vec_t;
  vec_t tbl [7];
  task automatic cmp(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, a, a, e, e);
    end
  endtask
  task automatic chk(input string n, input logic ev, input logic [7:0] ed, input logic [4:0] ec, input logic eo);
    logic ei;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    ei = ec >= 5'd12;
`else
    ei = 1'b0;
`endif
    cmp({n, ".rd_vld"}, int'(bus.rd_vld), int'(ev));
    cmp({n, ".rd_data"}, int'(bus.rd_data), int'(ed));
    cmp({n, ".count"}, int'(bus.count), int'(ec));
    cmp({n, ".empty"}, int'(bus.empty), int'(ec == 5'd0));
    cmp({n, ".full"}, int'(bus.full), int'(ec == 5'd16));
    cmp({n, ".overflow"}, int'(bus.overflow), int'(eo));
    cmp({n, ".irq"}, int'(bus.irq), int'(ei));
  endtask
  task automatic step(input logic wv, input logic [7:0] wd, input logic re, input logic oc);
    @(negedge clk);
    bus.wr_vld  = wv;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.wr_vld = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b0};
    #12;
    chk("reset", 1'b0, 8'h00, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].re, tbl[i].oc);
      chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("fill%0d", i), 1'b0, 8'h3C, 5'(i + 1), 1'b0);
    end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("drop55", 1'b0, 8'h3C, 5'd16, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 1'b0, 8'h3C, 5'd16, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    chk("clr_vs_drop", 1'b0, 8'h3C, 5'd16, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr2", 1'b0, 8'h3C, 5'd16, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("full_wr_rd", 1'b1, 8'h00, 5'd16, 1'b0);
    for (int i = 1; i < 17; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d", i), 1'b1, (i == 16) ? 8'h77 : 8'(i), 5'(16 - i), 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", 1'b0, 8'h77, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h81 + i), 1'b0, 1'b0);
      chk($sformatf("refill%0d", i), 1'b0, 8'h77, 5'(i + 1), 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst", 1'b1, 8'h81, 5'd9, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst", 1'b0, 8'h00, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.rd_en = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_rd", 1'b0, 8'h00, 5'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
